// File: rtl/id_run_stat_pkg.sv
// Shared constants and FSM encoding for the identifier run-length statistics block.
package id_run_stat_pkg;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/id_run_stat_if.sv
// Recognizer-side input, FIFO read port and statistics outputs of id_run_stat.
interface id_run_stat_if
    import id_run_stat_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             match;
    logic             rd_en;
    logic [LEN_W-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             done;
    logic [LEN_W-1:0] last_len;
    logic [LEN_W-1:0] max_len;
    logic [CNT_W-1:0] id_count;
    logic             cnt_ovf;
    logic             drop;

    modport master (
        output match, rd_en,
        input  rd_data, empty, full, done, last_len, max_len, id_count, cnt_ovf, drop
    );

    modport slave (
        input  match, rd_en,
        output rd_data, empty, full, done, last_len, max_len, id_count, cnt_ovf, drop
    );
endinterface

// File: rtl/id_len_fifo.sv
// Show-ahead FIFO of completed run lengths; a full FIFO accepts a push only alongside a pop.
module id_len_fifo
    import id_run_stat_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [LEN_W-1:0] push_data,
    input  logic             pop,
    output logic [LEN_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/id_run_stat.sv
// Edge detection, run-length FSM and running statistics over the recognizer match stream.
module id_run_stat
    import id_run_stat_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    id_run_stat_if.slave bus
);
    state_e           state_q, state_d;
    logic             prev_q;
    logic [LEN_W-1:0] run_len_q, run_len_d;
    logic [LEN_W-1:0] last_len_q, last_len_d;
    logic [LEN_W-1:0] max_len_q, max_len_d;
    logic [CNT_W-1:0] id_count_q, id_count_d;
    logic             cnt_ovf_q, cnt_ovf_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic             start, cont, stop;
    logic             push, overflow;

    assign start = !prev_q && bus.match;
    assign cont  =  prev_q && bus.match;
    assign stop  =  prev_q && !bus.match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b0;
            run_len_q  <= '0;
            last_len_q <= '0;
            max_len_q  <= '0;
            id_count_q <= '0;
            cnt_ovf_q  <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= bus.match;
            run_len_q  <= run_len_d;
            last_len_q <= last_len_d;
            max_len_q  <= max_len_d;
            id_count_q <= id_count_d;
            cnt_ovf_q  <= cnt_ovf_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_len_d  = run_len_q;
        last_len_d = last_len_q;
        max_len_d  = max_len_q;
        id_count_d = id_count_q;
        cnt_ovf_d  = cnt_ovf_q;
        done_d     = 1'b0;
        push       = 1'b0;
        drop_d     = drop_q || overflow;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    run_len_d = LEN_W'(1);
                    if (id_count_q == '1) cnt_ovf_d  = 1'b1;
                    else                  id_count_d = id_count_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cont && run_len_q != '1) run_len_d = run_len_q + 1'b1;
                if (stop) begin
                    state_d    = S_IDLE;
                    last_len_d = run_len_q;
                    if (run_len_q > max_len_q) max_len_d = run_len_q;
                    done_d     = 1'b1;
                    push       = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    id_len_fifo #(.LEN_W(LEN_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (run_len_q),
        .pop       (bus.rd_en),
        .rd_data   (bus.rd_data),
        .empty     (bus.empty),
        .full      (bus.full),
        .overflow  (overflow)
    );

    assign bus.done     = done_q;
    assign bus.last_len = last_len_q;
    assign bus.max_len  = max_len_q;
    assign bus.id_count = id_count_q;
    assign bus.cnt_ovf  = cnt_ovf_q;
    assign bus.drop     = drop_q;
endmodule

// File: tb/tb_id_run_stat.sv
// Directed-vector bench for id_run_stat: default instance plus a CNT_W=2 instance for counter saturation.
module tb_id_run_stat;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic match = 1'b0;
    logic rd_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_run_stat_if #(.LEN_W(8), .CNT_W(16)) if_a ();
    id_run_stat_if #(.LEN_W(8), .CNT_W(2))  if_b ();

    assign if_a.match = match;
    assign if_a.rd_en = rd_en;
    assign if_b.match = match;
    assign if_b.rd_en = rd_en;

    id_run_stat #(.LEN_W(8), .CNT_W(16), .DEPTH(4)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    id_run_stat #(.LEN_W(8), .CNT_W(2), .DEPTH(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    typedef struct {
        bit rs;
        bit m;
        bit r;
        bit done;
        int last;
        int mx;
        int rd;
        bit empty;
        bit full;
        bit drop;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rs, bit m, bit r, bit done, int last, int mx, int rd,
                                bit empty, bit full, bit drop, int cnt);
        vec_t v;
        v.rs = rs; v.m = m; v.r = r; v.done = done; v.last = last; v.mx = mx; v.rd = rd;
        v.empty = empty; v.full = full; v.drop = drop; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input bit m, input bit r);
        match = m;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit pop_on_end);
        repeat (n) step(1'b1, 1'b0);
        step(1'b0, pop_on_end);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rs m r | done last max rd empty full drop cnt
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 3, 3, 3, 0, 0, 0, 1);
        add(0, 0, 0, 0, 3, 3, 3, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 2, 2, 2, 0, 0, 0, 1);
        add(0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 2);
        add(0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 2);
        add(0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 2);
        add(0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 2);
        add(0, 1, 0, 0, 2, 2, 2, 0, 0, 0, 2);
        add(0, 0, 0, 1, 5, 5, 2, 0, 0, 0, 2);
        add(0, 1, 0, 0, 5, 5, 2, 0, 0, 0, 3);
        add(0, 0, 0, 1, 1, 5, 2, 0, 0, 0, 3);
        add(0, 0, 1, 0, 1, 5, 5, 0, 0, 0, 3);
        add(0, 0, 1, 0, 1, 5, 1, 0, 0, 0, 3);
        add(0, 0, 1, 0, 1, 5, 0, 1, 0, 0, 3);
        add(0, 0, 1, 0, 1, 5, 0, 1, 0, 0, 3);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            step(tbl[i].m, tbl[i].r);
            chk($sformatf("v%0d.done", i),  32'(if_a.done),     32'(tbl[i].done));
            chk($sformatf("v%0d.last", i),  32'(if_a.last_len), 32'(tbl[i].last));
            chk($sformatf("v%0d.max", i),   32'(if_a.max_len),  32'(tbl[i].mx));
            chk($sformatf("v%0d.rd", i),    32'(if_a.rd_data),  32'(tbl[i].rd));
            chk($sformatf("v%0d.empty", i), 32'(if_a.empty),    32'(tbl[i].empty));
            chk($sformatf("v%0d.full", i),  32'(if_a.full),     32'(tbl[i].full));
            chk($sformatf("v%0d.drop", i),  32'(if_a.drop),     32'(tbl[i].drop));
            chk($sformatf("v%0d.cnt", i),   32'(if_a.id_count), 32'(tbl[i].cnt));
        end

        // Overflow: five runs into a four-deep FIFO
        do_reset();
        run(1, 0); run(2, 0); run(3, 0);
        chk("t3.full_at3", 32'(if_a.full), 32'd0);
        run(4, 0);
        chk("t3.full_at4", 32'(if_a.full), 32'd1);
        chk("t3.drop_at4", 32'(if_a.drop), 32'd0);
        run(5, 0);
        chk("t3.done", 32'(if_a.done),     32'd1);
        chk("t3.drop", 32'(if_a.drop),     32'd1);
        chk("t3.last", 32'(if_a.last_len), 32'd5);
        chk("t3.max",  32'(if_a.max_len),  32'd5);
        step(0, 0);
        chk("t3.done_low", 32'(if_a.done), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t3.pop%0d", k), 32'(if_a.rd_data), 32'(k));
            step(0, 1);
        end
        chk("t3.empty", 32'(if_a.empty), 32'd1);

        // Full FIFO: END coincides with a pop
        do_reset();
        run(1, 0); run(2, 0); run(3, 0); run(4, 0);
        run(2, 1);
        chk("t4.done", 32'(if_a.done),     32'd1);
        chk("t4.full", 32'(if_a.full),     32'd1);
        chk("t4.drop", 32'(if_a.drop),     32'd0);
        chk("t4.last", 32'(if_a.last_len), 32'd2);
        begin
            int exp_q[4] = '{2, 3, 4, 2};
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t4.pop%0d", k), 32'(if_a.rd_data), 32'(exp_q[k]));
                step(0, 1);
            end
        end
        chk("t4.empty", 32'(if_a.empty), 32'd1);

        // Run length saturation
        do_reset();
        repeat (300) step(1, 0);
        chk("t5.last_mid", 32'(if_a.last_len), 32'd0);
        step(0, 0);
        chk("t5.last", 32'(if_a.last_len), 32'd255);
        chk("t5.max",  32'(if_a.max_len),  32'd255);
        chk("t5.rd",   32'(if_a.rd_data),  32'd255);

        // Asynchronous reset in the middle of a run
        repeat (3) step(1, 0);
        chk("t6.cnt_pre", 32'(if_a.id_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("t6.rst_cnt",   32'(if_a.id_count), 32'd0);
        chk("t6.rst_last",  32'(if_a.last_len), 32'd0);
        chk("t6.rst_max",   32'(if_a.max_len),  32'd0);
        chk("t6.rst_empty", 32'(if_a.empty),    32'd1);
        chk("t6.rst_rd",    32'(if_a.rd_data),  32'd0);
        chk("t6.rst_done",  32'(if_a.done),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        chk("t6.cnt",  32'(if_a.id_count), 32'd1);
        chk("t6.last", 32'(if_a.last_len), 32'd2);
        chk("t6.done", 32'(if_a.done),     32'd1);

        // Identifier counter saturation on the CNT_W=2 instance
        do_reset();
        run(1, 0); run(1, 0); run(1, 0);
        chk("t5.b_cnt3", 32'(if_b.id_count), 32'd3);
        chk("t5.b_ovf3", 32'(if_b.cnt_ovf),  32'd0);
        run(1, 0);
        chk("t5.b_cnt4", 32'(if_b.id_count), 32'd3);
        chk("t5.b_ovf4", 32'(if_b.cnt_ovf),  32'd1);
        chk("t5.a_cnt4", 32'(if_a.id_count), 32'd4);
        chk("t5.a_ovf4", 32'(if_a.cnt_ovf),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
